// File: rtl/axi_cmd_arbiter.sv
// Two-requester round-robin front end for a single AXI-lite master.
// One command at a time: grant in IDLE, pulse start in ISSUE, wait for the response or a timeout, report in DONE.
module axi_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        start_write,
  output logic        start_read,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  input  logic        bready,
  input  logic        rvalid,
  input  logic        rready,
  input  logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic        last_grant_r, last_grant_s;
  logic        gnt_r, gnt_s;
  logic        is_write_r, is_write_s;
  logic [15:0] cnt_r, cnt_s;
  logic        complete_s;
  logic [31:0] rd_capture_s;
  logic [31:0] addr_s, data_s;
  logic [3:0]  wstrb_s;
  logic        req0_ready_s, req1_ready_s, req0_done_s, req1_done_s;
  logic [31:0] req0_rdata_s, req1_rdata_s;
  logic        req0_err_s, req1_err_s;
  logic        start_write_s, start_read_s, busy_s;

  // Next-state and next-output logic; ISSUE spans two cycles so ready and start land in separate cycles.
  always_comb begin
    state_s       = state_r;
    last_grant_s  = last_grant_r;
    gnt_s         = gnt_r;
    is_write_s    = is_write_r;
    cnt_s         = cnt_r;
    addr_s        = addr;
    data_s        = data;
    wstrb_s       = wstrb;
    req0_ready_s  = 1'b0;
    req1_ready_s  = 1'b0;
    req0_done_s   = 1'b0;
    req1_done_s   = 1'b0;
    req0_rdata_s  = req0_rdata;
    req1_rdata_s  = req1_rdata;
    req0_err_s    = req0_err;
    req1_err_s    = req1_err;
    start_write_s = 1'b0;
    start_read_s  = 1'b0;
    complete_s    = is_write_r ? (bvalid && bready) : (rvalid && rready);
    rd_capture_s  = (complete_s && !is_write_r) ? rdata : 32'd0;
    case (state_r)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) begin
            gnt_s = ~last_grant_r;
          end else begin
            gnt_s = req1_valid;
          end
          last_grant_s = gnt_s;
          if (gnt_s) begin
            is_write_s   = req1_write;
            addr_s       = req1_addr;
            data_s       = req1_wdata;
            wstrb_s      = req1_wstrb;
            req1_ready_s = 1'b1;
          end else begin
            is_write_s   = req0_write;
            addr_s       = req0_addr;
            data_s       = req0_wdata;
            wstrb_s      = req0_wstrb;
            req0_ready_s = 1'b1;
          end
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s = 16'd0;
        if (start_write || start_read) begin
          state_s = WAIT;
        end else begin
          start_write_s = is_write_r;
          start_read_s  = ~is_write_r;
        end
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (complete_s || (cnt_r == CNT_LAST)) begin
          state_s = DONE;
          if (gnt_r) begin
            req1_done_s  = 1'b1;
            req1_rdata_s = rd_capture_s;
            req1_err_s   = ~complete_s;
          end else begin
            req0_done_s  = 1'b1;
            req0_rdata_s = rd_capture_s;
            req0_err_s   = ~complete_s;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset clears everything and favours req0 on first contention.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      is_write_r   <= 1'b0;
      cnt_r        <= 16'd0;
      addr         <= 32'd0;
      data         <= 32'd0;
      wstrb        <= 4'd0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_rdata   <= 32'd0;
      req1_rdata   <= 32'd0;
      req0_err     <= 1'b0;
      req1_err     <= 1'b0;
      start_write  <= 1'b0;
      start_read   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      gnt_r        <= gnt_s;
      is_write_r   <= is_write_s;
      cnt_r        <= cnt_s;
      addr         <= addr_s;
      data         <= data_s;
      wstrb        <= wstrb_s;
      req0_ready   <= req0_ready_s;
      req1_ready   <= req1_ready_s;
      req0_done    <= req0_done_s;
      req1_done    <= req1_done_s;
      req0_rdata   <= req0_rdata_s;
      req1_rdata   <= req1_rdata_s;
      req0_err     <= req0_err_s;
      req1_err     <= req1_err_s;
      start_write  <= start_write_s;
      start_read   <= start_read_s;
      busy         <= busy_s;
    end
  end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Bench for axi_cmd_arbiter: directed vector table, randomized transactions against a
// transaction-level model, and an asynchronous reset in the middle of WAIT.
module tb_axi_cmd_arbiter;

  localparam int TMO = 8;

  logic        aclk;
  logic        areset_n;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_wstrb, req1_wstrb;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        start_write, start_read;
  logic [31:0] addr, data;
  logic [3:0]  wstrb;
  logic        bvalid, bready, rvalid, rready;
  logic [31:0] rdata;
  logic        busy;

  axi_cmd_arbiter #(.TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .start_write(start_write), .start_read(start_read),
    .addr(addr), .data(data), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // k = WAIT cycle (1-based) in which the response handshake is offered; 0 = never.
  typedef struct {
    logic        v0, v1, w0, w1;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  s0, s1;
    int          k;
    logic [31:0] rd;
    logic        noise;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: requester that won last, and the values each requester should be holding.
  logic        last_m;
  logic [31:0] exp_rd [2];
  logic        exp_er [2];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {19'd0, busy, start_write, start_read, addr, data, wstrb,
            req0_ready, req1_ready, req0_done, req1_done,
            req0_rdata, req1_rdata, req0_err, req1_err};
  endfunction

  function automatic vec_t mk(logic v0, logic v1, logic w0, logic w1,
                              logic [31:0] a0, logic [31:0] d0, logic [3:0] s0,
                              logic [31:0] a1, logic [31:0] d1, logic [3:0] s1,
                              int k, logic [31:0] rd, logic noise);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.w0 = w0; t.w1 = w1;
    t.a0 = a0; t.d0 = d0; t.s0 = s0; t.a1 = a1; t.d1 = d1; t.s1 = s1;
    t.k = k; t.rd = rd; t.noise = noise;
    return t;
  endfunction

  task automatic clear_resp();
    bvalid = 1'b0; bready = 1'b0; rvalid = 1'b0; rready = 1'b0; rdata = 32'd0;
  endtask

  // Starts at a falling edge with the DUT in IDLE; ends at a falling edge back in IDLE.
  task automatic run_txn(input vec_t t, input string tag);
    logic        g, gw, e_err, rdy_ok, kind_ok, cmd_ok, done_ok, busy_ok;
    logic [31:0] ea, ed, erd;
    logic [3:0]  es;
    int          r_cyc, s_cyc, d_cyc, extra, wlen;
    check($sformatf("%s.idle_busy", tag), {159'd0, busy}, 160'd0);
    req0_valid = t.v0; req0_write = t.w0; req0_addr = t.a0; req0_wdata = t.d0; req0_wstrb = t.s0;
    req1_valid = t.v1; req1_write = t.w1; req1_addr = t.a1; req1_wdata = t.d1; req1_wstrb = t.s1;
    g      = (t.v0 && t.v1) ? ~last_m : t.v1;
    last_m = g;
    gw     = g ? t.w1 : t.w0;
    ea     = g ? t.a1 : t.a0;
    ed     = g ? t.d1 : t.d0;
    es     = g ? t.s1 : t.s0;
    e_err  = !(t.k > 0 && t.k <= TMO);
    wlen   = e_err ? TMO : t.k;
    erd    = (!gw && !e_err) ? t.rd : 32'd0;
    r_cyc = -1; s_cyc = -1; d_cyc = -1; extra = 0;
    rdy_ok = 1'b0; kind_ok = 1'b0; cmd_ok = 1'b0; done_ok = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 40 && d_cyc < 0; c++) begin
      @(negedge aclk);
      if (req0_ready || req1_ready) begin
        if (r_cyc < 0) begin
          r_cyc  = c;
          rdy_ok = (req0_ready == !g) && (req1_ready == g);
        end else begin
          extra++;
        end
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
      if (start_write || start_read) begin
        if (s_cyc < 0) begin
          s_cyc   = c;
          kind_ok = (start_write == gw) && (start_read == !gw);
          cmd_ok  = (addr == ea) && (data == ed) && (wstrb == es);
        end else begin
          extra++;
        end
      end
      if (req0_done || req1_done) begin
        d_cyc   = c;
        done_ok = (req0_done == !g) && (req1_done == g);
      end
      if (!busy) busy_ok = 1'b0;
      clear_resp();
      if (t.noise && c == 1) begin
        bvalid = 1'b1; bready = 1'b1; rvalid = 1'b1; rready = 1'b1; rdata = 32'hDEAD_BEEF;
      end
      if (s_cyc > 0 && d_cyc < 0 && t.noise && c == s_cyc + 1 && t.k != 1) begin
        if (gw) begin rvalid = 1'b1; rready = 1'b1; end
        else begin bvalid = 1'b1; bready = 1'b1; end
        rdata = 32'hBAD0_0BAD;
      end
      if (s_cyc > 0 && t.k > 0 && c == s_cyc + t.k) begin
        if (gw) begin bvalid = 1'b1; bready = 1'b1; end
        else begin rvalid = 1'b1; rready = 1'b1; rdata = t.rd; end
      end
    end
    exp_rd[g] = erd;
    exp_er[g] = e_err;
    check($sformatf("%s.ready_cycle", tag), 160'(r_cyc), 160'd1);
    check($sformatf("%s.ready_who", tag), {159'd0, rdy_ok}, 160'd1);
    check($sformatf("%s.start_cycle", tag), 160'(s_cyc), 160'd2);
    check($sformatf("%s.start_kind", tag), {159'd0, kind_ok}, 160'd1);
    check($sformatf("%s.cmd_out", tag), {159'd0, cmd_ok}, 160'd1);
    check($sformatf("%s.done_cycle", tag), 160'(d_cyc), 160'(3 + wlen));
    check($sformatf("%s.done_who", tag), {159'd0, done_ok}, 160'd1);
    check($sformatf("%s.extra_pulses", tag), 160'(extra), 160'd0);
    check($sformatf("%s.busy", tag), {159'd0, busy_ok}, 160'd1);
    check($sformatf("%s.rdata", tag), {96'd0, req0_rdata, req1_rdata}, {96'd0, exp_rd[0], exp_rd[1]});
    check($sformatf("%s.err", tag), {158'd0, req0_err, req1_err}, {158'd0, exp_er[0], exp_er[1]});
    clear_resp();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge aclk);
    check($sformatf("%s.back_idle", tag),
          {155'd0, busy, req0_done, req1_done, req0_ready, req1_ready}, 160'd0);
  endtask

  vec_t tbl [12];
  vec_t rv;
  logic saw_bad;

  initial begin
    // Directed vectors: six-way contention first, then single requesters and timeout edges.
    tbl[0]  = mk(1, 1, 1, 0, 32'h4, 32'hA5, 4'hF, 32'h8, 32'h0, 4'h0, 3, 32'h0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 32'h4, 32'hA5, 4'hF, 32'h8, 32'h0, 4'h0, 2, 32'h1234_5678, 0);
    tbl[2]  = mk(1, 1, 0, 1, 32'h10, 32'h0, 4'h0, 32'h14, 32'hCAFE, 4'h3, 1, 32'h0F0F_0F0F, 0);
    tbl[3]  = mk(1, 1, 0, 1, 32'h10, 32'h0, 4'h0, 32'h14, 32'hCAFE, 4'h3, 4, 32'h0, 0);
    tbl[4]  = mk(1, 1, 1, 1, 32'h20, 32'h77, 4'h1, 32'h24, 32'h88, 4'h2, 6, 32'h0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 32'h30, 32'h0, 4'h0, 32'h34, 32'h0, 4'h0, 8, 32'hAAAA_5555, 0);
    tbl[6]  = mk(0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h44, 32'h0, 4'h0, 2, 32'h1111_2222, 0);
    tbl[7]  = mk(1, 0, 1, 0, 32'h50, 32'h99, 4'hC, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 32'h60, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, TMO, 32'h3333_4444, 1);
    tbl[9]  = mk(0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h74, 32'h0, 4'h0, TMO + 1, 32'h5555_6666, 0);
    tbl[10] = mk(1, 0, 0, 0, 32'h80, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 32'h5A5A_5A5A, 1);
    tbl[11] = mk(0, 1, 0, 1, 32'h0, 32'h0, 4'h0, 32'h94, 32'h1357, 4'h6, 5, 32'h0, 1);

    areset_n = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h4; req0_wdata = 32'h1; req0_wstrb = 4'hF;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h8; req1_wdata = 32'h2; req1_wstrb = 4'h1;
    clear_resp();
    #1 areset_n = 1'b0;
    last_m = 1'b1;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outputs", all_outs(), 160'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    areset_n = 1'b1;
    @(negedge aclk);
    check("post_reset_idle", all_outs(), 160'd0);

    for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.v0 = 1'($urandom_range(0, 1));
      rv.v1 = 1'($urandom_range(0, 1));
      if (!rv.v0 && !rv.v1) rv.v0 = 1'b1;
      rv.w0 = 1'($urandom_range(0, 1));
      rv.w1 = 1'($urandom_range(0, 1));
      rv.a0 = $urandom; rv.d0 = $urandom; rv.s0 = 4'($urandom_range(0, 15));
      rv.a1 = $urandom; rv.d1 = $urandom; rv.s1 = 4'($urandom_range(0, 15));
      rv.k  = int'($urandom_range(0, TMO + 2));
      rv.rd = $urandom;
      rv.noise = 1'($urandom_range(0, 1));
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset two cycles into WAIT of a req1 read.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'hC0; req1_wdata = 32'h0; req1_wstrb = 4'h0;
    repeat (4) @(negedge aclk);
    req1_valid = 1'b0;
    check("midwait_busy", {159'd0, busy}, 160'd1);
    #2 areset_n = 1'b0;
    #1 check("midwait_async_clear", all_outs(), 160'd0);
    last_m = 1'b1;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    @(negedge aclk);
    check("midwait_held", all_outs(), 160'd0);
    areset_n = 1'b1;
    saw_bad = 1'b0;
    repeat (5) begin
      @(negedge aclk);
      if (req0_done || req1_done || busy) saw_bad = 1'b1;
    end
    check("midwait_no_done", {159'd0, saw_bad}, 160'd0);
    run_txn(tbl[0], "after_reset");
    run_txn(tbl[1], "after_reset2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
